wb_tagged_ram: RTL and testbench

//  Parametrised Wishbone-classic RAM with per-granule memory tags; successor of the fixed 32-bit tagged RAM.

---
 rtl/wb_tagged_ram_pkg.sv | 23 ++
 rtl/generic_ram.sv | 20 ++
 rtl/wb_byte_lane_merge.sv | 18 +
 rtl/wb_tagged_ram.sv | 163 ++++++++++++++++
 tb/tb_wb_tagged_ram.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_tagged_ram_pkg.sv
// Shared types and sizing helpers for the Wishbone tagged RAM.
package wb_tagged_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK
  } ram_state_t;

  localparam int LANE_BITS = 8;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int lane_count(input int data_width);
    return data_width / LANE_BITS;
  endfunction

endpackage

// File: rtl/generic_ram.sv
// Single-port synchronous RAM with read-before-write behaviour.
module generic_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_byte_lane_merge.sv
// Combinational per-byte mux: enabled lanes take the new word, others keep the old one.
module wb_byte_lane_merge
  import wb_tagged_ram_pkg::*;
#(
  parameter int SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH*LANE_BITS-1:0] old_word,
  input  logic [SEL_WIDTH*LANE_BITS-1:0] new_word,
  input  logic [SEL_WIDTH-1:0]           sel,
  output logic [SEL_WIDTH*LANE_BITS-1:0] merged
);

  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_lane
    assign merged[i*LANE_BITS +: LANE_BITS] =
      sel[i] ? new_word[i*LANE_BITS +: LANE_BITS] : old_word[i*LANE_BITS +: LANE_BITS];
  end

endmodule

// File: rtl/wb_tagged_ram.sv
// Wishbone-classic RAM with per-granule memory tags and optional tag checking.
// Define WB_TAGGED_RAM_FAULT_INFO_EN to expose the address/direction of the first faulting access.
module wb_tagged_ram
  import wb_tagged_ram_pkg::*;
#(
  parameter int WB_DATA_WIDTH      = 32,
  parameter int WB_ADDR_WIDTH      = 32,
  parameter int WB_SEL_WIDTH       = WB_DATA_WIDTH / 8,
  parameter int WB_RAM_WORDS       = 1024,
  parameter int GRANULE_SIZE_BYTES = 16,
  parameter int GRANULE_TAG_WIDTH  = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_tag_i,
  input  logic                     check_tags_i,
  input  logic                     clear_mismatch_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     tag_mismatch_o
`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
  ,
  output logic [WB_ADDR_WIDTH-1:0] fault_addr_o,
  output logic                     fault_we_o
`endif
);

  localparam int SEL_LSB     = log2_ceil(WB_SEL_WIDTH);
  localparam int WORD_AW     = log2_ceil(WB_RAM_WORDS);
  localparam int GRAN_LSB    = log2_ceil(GRANULE_SIZE_BYTES);
  localparam int GRAN_COUNT  = WB_RAM_WORDS * WB_SEL_WIDTH / GRANULE_SIZE_BYTES;
  localparam int GRAN_AW     = log2_ceil(GRAN_COUNT);
  localparam int TW          = GRANULE_TAG_WIDTH;

  ram_state_t state_q, state_d;

  logic                     req;
  logic [WORD_AW-1:0]       word_idx;
  logic [GRAN_AW-1:0]       gran_idx;
  logic [TW-1:0]            addr_tag;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;
  logic [WB_DATA_WIDTH-1:0] merged_word;
  logic [TW-1:0]            tag_rdata;
  logic                     mismatch;
  logic                     data_we;
  logic                     tag_we;
  logic                     fault_set;
  logic [WB_DATA_WIDTH-1:0] read_q;
  logic                     unused_addr;

  assign req         = wb_cyc_i & wb_stb_i;
  assign word_idx    = wb_addr_i[SEL_LSB +: WORD_AW];
  assign gran_idx    = wb_addr_i[GRAN_LSB +: GRAN_AW];
  assign addr_tag    = wb_addr_i[WB_ADDR_WIDTH-1 -: TW];
  assign mismatch    = (addr_tag != tag_rdata);
  assign unused_addr = ^wb_addr_i;

  generic_ram #(
    .DATA_WIDTH(WB_DATA_WIDTH),
    .ADDR_WIDTH(WORD_AW)
  ) u_data_ram (
    .clk  (wb_clk_i),
    .we   (data_we),
    .addr (word_idx),
    .wdata(merged_word),
    .rdata(ram_rdata)
  );

  generic_ram #(
    .DATA_WIDTH(TW),
    .ADDR_WIDTH(GRAN_AW)
  ) u_tag_ram (
    .clk  (wb_clk_i),
    .we   (tag_we),
    .addr (gran_idx),
    .wdata(wb_data_i[TW-1:0]),
    .rdata(tag_rdata)
  );

  wb_byte_lane_merge #(
    .SEL_WIDTH(WB_SEL_WIDTH)
  ) u_merge (
    .old_word(ram_rdata),
    .new_word(wb_data_i),
    .sel     (wb_sel_i),
    .merged  (merged_word)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = req ? ST_ACK : ST_IDLE;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Writes are gated by reset so an access interrupted by reset leaves both RAMs untouched.
  always_comb begin
    data_we   = 1'b0;
    tag_we    = 1'b0;
    fault_set = 1'b0;
    wb_ack_o  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        if (req && !wb_rst_i) begin
          if (wb_tag_i) begin
            tag_we = wb_we_i;
          end else begin
            fault_set = check_tags_i && mismatch;
            data_we   = wb_we_i && !(check_tags_i && mismatch);
          end
        end
      end
      ST_ACK:  wb_ack_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      read_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (wb_tag_i)                      read_q <= {{(WB_DATA_WIDTH-TW){1'b0}}, tag_rdata};
      else if (check_tags_i && mismatch) read_q <= '0;
      else                               read_q <= ram_rdata;
    end
  end

  assign wb_data_o = wb_ack_o ? read_q : '0;

  // A new fault outranks a simultaneous clear so no fault is ever lost.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)              tag_mismatch_o <= 1'b0;
    else if (fault_set)        tag_mismatch_o <= 1'b1;
    else if (clear_mismatch_i) tag_mismatch_o <= 1'b0;
  end

`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fault_addr_o <= '0;
      fault_we_o   <= 1'b0;
    end else if (fault_set && (!tag_mismatch_o || clear_mismatch_i)) begin
      fault_addr_o <= wb_addr_i;
      fault_we_o   <= wb_we_i;
    end
  end
`endif

endmodule

// File: tb/tb_wb_tagged_ram.sv
// Directed self-checking bench for wb_tagged_ram (32-bit and 64-bit instances).
// Fault-info checks are compiled in when WB_TAGGED_RAM_FAULT_INFO_EN is defined.
module tb_wb_tagged_ram;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_tag_i;
  logic        check_tags_i, clear_mismatch_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        tag_mismatch_o;

  logic [31:0] addr64;
  logic [63:0] wdata64;
  logic [7:0]  sel64;
  logic        we64, stb64;
  logic        ack64;
  logic [63:0] rdata64_o;
  logic        mismatch64;

`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
  logic [31:0] fault_addr_o, fault_addr64;
  logic        fault_we_o, fault_we64;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic [63:0] rd64;
  logic        flag;

  wb_tagged_ram u_dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .wb_sel_i        (wb_sel_i),
    .wb_we_i         (wb_we_i),
    .wb_cyc_i        (wb_cyc_i),
    .wb_stb_i        (wb_stb_i),
    .wb_tag_i        (wb_tag_i),
    .check_tags_i    (check_tags_i),
    .clear_mismatch_i(clear_mismatch_i),
    .wb_ack_o        (wb_ack_o),
    .wb_data_o       (wb_data_o),
    .tag_mismatch_o  (tag_mismatch_o)
`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
    ,
    .fault_addr_o    (fault_addr_o),
    .fault_we_o      (fault_we_o)
`endif
  );

  wb_tagged_ram #(.WB_DATA_WIDTH(64)) u_dut64 (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .wb_addr_i       (addr64),
    .wb_data_i       (wdata64),
    .wb_sel_i        (sel64),
    .wb_we_i         (we64),
    .wb_cyc_i        (stb64),
    .wb_stb_i        (stb64),
    .wb_tag_i        (1'b0),
    .check_tags_i    (1'b0),
    .clear_mismatch_i(1'b0),
    .wb_ack_o        (ack64),
    .wb_data_o       (rdata64_o),
    .tag_mismatch_o  (mismatch64)
`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
    ,
    .fault_addr_o    (fault_addr64),
    .fault_we_o      (fault_we64)
`endif
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete 32-bit bus transaction; also checks latency, ack width and idle data.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel, input logic we, input logic tag_acc,
                               input logic check, input logic clr,
                               output logic [31:0] rdata, output logic flag_at_ack);
    int cycles;
    logic got;
    @(posedge wb_clk_i); #1;
    wb_addr_i = addr; wb_data_i = data; wb_sel_i = sel; wb_we_i = we;
    wb_tag_i = tag_acc; check_tags_i = check; clear_mismatch_i = clr;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    cycles = 0; got = 1'b0; rdata = '0; flag_at_ack = 1'b0;
    while (!got && cycles < 8) begin
      @(posedge wb_clk_i); #1;
      cycles++;
      if (wb_ack_o) begin
        got = 1'b1;
        rdata = wb_data_o;
        flag_at_ack = tag_mismatch_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; clear_mismatch_i = 1'b0;
    checkOutput({tag, "_ack_seen"}, 64'(got), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd2);
    @(posedge wb_clk_i); #1;
    checkOutput({tag, "_ack_one_cycle"}, 64'(wb_ack_o), 64'd0);
    checkOutput({tag, "_data_idle"}, 64'(wb_data_o), 64'd0);
  endtask

  task automatic applyStimulus64(input string tag, input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] sel, input logic we, output logic [63:0] rdata);
    int cycles;
    logic got;
    @(posedge wb_clk_i); #1;
    addr64 = addr; wdata64 = data; sel64 = sel; we64 = we; stb64 = 1'b1;
    cycles = 0; got = 1'b0; rdata = '0;
    while (!got && cycles < 8) begin
      @(posedge wb_clk_i); #1;
      cycles++;
      if (ack64) begin
        got = 1'b1;
        rdata = rdata64_o;
      end
    end
    stb64 = 1'b0;
    checkOutput({tag, "_ack_seen"}, 64'(got), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd2);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_tag_i = 1'b0;
    check_tags_i = 1'b0; clear_mismatch_i = 1'b0;
    addr64 = '0; wdata64 = '0; sel64 = '0; we64 = 1'b0; stb64 = 1'b0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("reset_ack", 64'(wb_ack_o), 64'd0);
    checkOutput("reset_data", 64'(wb_data_o), 64'd0);
    checkOutput("reset_flag", 64'(tag_mismatch_o), 64'd0);
`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
    checkOutput("reset_fault_addr", 64'(fault_addr_o), 64'd0);
    checkOutput("reset_fault_we", 64'(fault_we_o), 64'd0);
`endif
    wb_rst_i = 1'b0;

    applyStimulus("wr_full", 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, rd, flag);
    applyStimulus("rd_full", 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_full_data", 64'(rd), 64'hDEADBEEF);

    applyStimulus("wr_lane1", 32'h41, 32'h0000AA00, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, rd, flag);
    applyStimulus("rd_lane1", 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_lane1_data", 64'(rd), 64'hDEADAAEF);

    applyStimulus("wr_44", 32'h44, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, rd, flag);
    applyStimulus("wr_tag40", 32'h40, 32'h5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, rd, flag);
    applyStimulus("wr_tag50", 32'h50, 32'h5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, rd, flag);
    applyStimulus("rd_tag40", 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_tag40_data", 64'(rd), 64'h5);

    applyStimulus("chk_match", 32'h5000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, rd, flag);
    checkOutput("chk_match_data", 64'(rd), 64'hDEADAAEF);
    checkOutput("chk_match_flag", 64'(flag), 64'd0);

    applyStimulus("chk_miss", 32'h3000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, rd, flag);
    checkOutput("chk_miss_data", 64'(rd), 64'h0);
    checkOutput("chk_miss_flag", 64'(flag), 64'd1);

    @(posedge wb_clk_i); #1;
    clear_mismatch_i = 1'b1;
    @(posedge wb_clk_i); #1;
    clear_mismatch_i = 1'b0;
    checkOutput("clear_flag", 64'(tag_mismatch_o), 64'd0);

    applyStimulus("tag_rd_unchecked", 32'h3000_0040, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, rd, flag);
    checkOutput("tag_rd_unchecked_data", 64'(rd), 64'h5);
    checkOutput("tag_rd_unchecked_flag", 64'(flag), 64'd0);

    applyStimulus("fault_first", 32'h3000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, rd, flag);
    checkOutput("fault_first_flag", 64'(flag), 64'd1);
    applyStimulus("wr_blocked", 32'h3000_0044, 32'h1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, rd, flag);
    checkOutput("set_beats_clear_ack", 64'(flag), 64'd1);
    checkOutput("set_beats_clear_after", 64'(tag_mismatch_o), 64'd1);
    applyStimulus("rd_after_block", 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_after_block_data", 64'(rd), 64'h12345678);

    @(posedge wb_clk_i); #1;
    clear_mismatch_i = 1'b1;
    @(posedge wb_clk_i); #1;
    clear_mismatch_i = 1'b0;
    applyStimulus("info_read", 32'h3000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, rd, flag);
    applyStimulus("info_write", 32'h3000_0050, 32'h7, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, rd, flag);
    checkOutput("info_flag", 64'(tag_mismatch_o), 64'd1);
`ifdef WB_TAGGED_RAM_FAULT_INFO_EN
    checkOutput("info_fault_addr", 64'(fault_addr_o), 64'h3000_0040);
    checkOutput("info_fault_we", 64'(fault_we_o), 64'd0);
`endif

    applyStimulus("wr_48", 32'h48, 32'h11112222, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, rd, flag);

    @(posedge wb_clk_i); #1;
    wb_addr_i = 32'h48; wb_data_i = 32'hFFFFFFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_tag_i = 1'b0; check_tags_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0;
    @(posedge wb_clk_i); #1;
    checkOutput("abort_no_ack_1", 64'(wb_ack_o), 64'd0);
    @(posedge wb_clk_i); #1;
    checkOutput("abort_no_ack_2", 64'(wb_ack_o), 64'd0);
    wb_stb_i = 1'b0;
    applyStimulus("rd_after_abort", 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_after_abort_data", 64'(rd), 64'h11112222);

    @(posedge wb_clk_i); #1;
    wb_addr_i = 32'h48; wb_data_i = 32'hFFFFFFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    checkOutput("rst_mid_ack", 64'(wb_ack_o), 64'd0);
    checkOutput("rst_mid_data", 64'(wb_data_o), 64'd0);
    checkOutput("rst_mid_flag", 64'(tag_mismatch_o), 64'd0);
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    applyStimulus("rd_after_rst", 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_after_rst_data", 64'(rd), 64'h11112222);

    applyStimulus("wr_sel0", 32'h48, 32'hCAFEF00D, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, rd, flag);
    applyStimulus("rd_sel0", 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_sel0_data", 64'(rd), 64'h11112222);

    applyStimulus("rd_wrap", 32'h1040, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, flag);
    checkOutput("rd_wrap_data", 64'(rd), 64'hDEADAAEF);

    applyStimulus64("w64_full", 32'h80, 64'h0123456789ABCDEF, 8'hFF, 1'b1, rd64);
    applyStimulus64("w64_lane5", 32'h85, 64'h00005A0000000000, 8'h20, 1'b1, rd64);
    applyStimulus64("r64", 32'h80, 64'h0, 8'h00, 1'b0, rd64);
    checkOutput("r64_data", rd64, 64'h01235A6789ABCDEF);
    checkOutput("r64_flag", 64'(mismatch64), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
